// File: rtl/hdlc_tx_channel.sv
// HDLC transmit channel: opening flag, LSB-first data with zero insertion,
// closing flag, and abort sequence on request.
module hdlc_tx_channel (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_DataValid,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_AbortFrame,
    output logic       Tx_RdBuff,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Busy,
    output logic       Tx
);

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
        END_FLAG,
        ABORT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] ones_q, ones_d;
    logic       stuff_q, stuff_d;
    logic       tx_q, tx_d;
    logic       abrt_q, abrt_d;
    logic       byte_end;
    logic       abort_req;
    logic       load;

    // Flag 0x7E sent LSB first: 0,1,1,1,1,1,1,0
    function automatic logic flag_bit(input logic [2:0] idx);
        return (idx != 3'd0) && (idx != 3'd7);
    endfunction

    always_comb begin
        abort_req = Tx_AbortFrame &&
                    (state_q inside {START_FLAG, DATA, END_FLAG});
        // cnt_q holds the index of the data bit on the line
        byte_end  = (state_q == DATA) && (cnt_q == 3'd7) &&
                    (stuff_q || (ones_q != 3'd5));
        load      = !abort_req &&
                    (((state_q == START_FLAG) && (cnt_q == 3'd7)) ||
                     (byte_end && Tx_DataValid));

        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ones_d  = ones_q;
        stuff_d = stuff_q;
        tx_d    = tx_q;
        abrt_d  = 1'b0;

        if (abort_req) begin
            state_d = ABORT;
            cnt_d   = 3'd0;
            tx_d    = 1'b0;
            shreg_d = 8'd0;
            ones_d  = 3'd0;
            stuff_d = 1'b0;
            abrt_d  = 1'b1;
        end else if (load) begin
            state_d = DATA;
            cnt_d   = 3'd0;
            tx_d    = Tx_Data[0];
            shreg_d = {1'b0, Tx_Data[7:1]};
            ones_d  = Tx_Data[0] ? ones_q + 3'd1 : 3'd0;
            stuff_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (Tx_DataValid) begin
                        state_d = START_FLAG;
                        cnt_d   = 3'd0;
                        tx_d    = 1'b0;
                    end
                end
                START_FLAG: begin
                    cnt_d = cnt_q + 3'd1;
                    tx_d  = flag_bit(cnt_q + 3'd1);
                end
                DATA: begin
                    if (ones_q == 3'd5) begin
                        tx_d    = 1'b0;
                        ones_d  = 3'd0;
                        stuff_d = 1'b1;
                    end else if (byte_end) begin
                        state_d = END_FLAG;
                        cnt_d   = 3'd0;
                        tx_d    = 1'b0;
                        shreg_d = 8'd0;
                        ones_d  = 3'd0;
                        stuff_d = 1'b0;
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + 3'd1;
                        ones_d  = shreg_q[0] ? ones_q + 3'd1 : 3'd0;
                        stuff_d = 1'b0;
                    end
                end
                END_FLAG: begin
                    if (cnt_q == 3'd7) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        tx_d  = flag_bit(cnt_q + 3'd1);
                    end
                end
                ABORT: begin
                    tx_d = 1'b1;
                    if (cnt_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shreg_q <= 8'd0;
            ones_q  <= 3'd0;
            stuff_q <= 1'b0;
            tx_q    <= 1'b1;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ones_q  <= ones_d;
            stuff_q <= stuff_d;
            tx_q    <= tx_d;
            abrt_q  <= abrt_d;
        end
    end

    assign Tx_RdBuff       = load;
    assign Tx_AbortedTrans = abrt_q;
    assign Tx_Busy         = (state_q != IDLE);
    assign Tx              = tx_q;

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// Randomized bench for hdlc_tx_channel against a bit-stream reference
// model (flag + stuffed payload + flag, or truncated abort pattern).
module tb_hdlc_tx_channel;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Tx_DataValid;
    logic [7:0] Tx_Data;
    logic       Tx_AbortFrame;
    logic       Tx_RdBuff;
    logic       Tx_AbortedTrans;
    logic       Tx_Busy;
    logic       Tx;

    int n_chk = 0;
    int n_err = 0;
    int fno = 0;
    logic [7:0] fb[$];

    hdlc_tx_channel dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_DataValid   (Tx_DataValid),
        .Tx_Data        (Tx_Data),
        .Tx_AbortFrame  (Tx_AbortFrame),
        .Tx_RdBuff      (Tx_RdBuff),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .Tx_Busy        (Tx_Busy),
        .Tx             (Tx)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Entered at posedge+1; drives one cycle and checks it at negedge.
    task automatic step(input string p, input logic dv, input logic [7:0] d,
                        input logic ab, input logic etx, input logic ebusy,
                        input logic erd, input logic eabt);
        Tx_DataValid  = dv;
        Tx_Data       = d;
        Tx_AbortFrame = ab;
        @(negedge Clk);
        check({p, " tx"}, Tx, etx);
        check({p, " busy"}, Tx_Busy, ebusy);
        check({p, " rdbuff"}, Tx_RdBuff, erd);
        check({p, " aborted"}, Tx_AbortedTrans, eabt);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n, input bit start);
        for (int i = 0; i < n; i++) begin
            step($sformatf("idle f%0d c%0d", fno, i),
                 start && (i == n - 1), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // abort_mode: -1 none, -2 random cycle, >=0 abort asserted in that cycle
    task automatic run_frame(input int abort_mode);
        bit         ftx[$];
        int         endpos[$];
        int         rdpos[$];
        logic [7:0] flag;
        int         ones;
        int         len;
        int         ab_at;
        int         total;
        int         last_end;
        bit         v;
        logic       dv;
        logic [7:0] d;
        logic       ab;
        logic       etx;
        logic       erd;
        logic       eabt;
        flag = 8'h7E;
        ones = 0;
        for (int b = 0; b < 8; b++) ftx.push_back(flag[b]);
        for (int i = 0; i < fb.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                v = fb[i][b];
                ftx.push_back(v);
                ones = v ? ones + 1 : 0;
                if (b == 7) endpos.push_back(ftx.size() - 1);
                if (ones == 5) begin
                    ftx.push_back(1'b0);
                    ones = 0;
                    if (b == 7) endpos[i] = endpos[i] + 1;
                end
            end
        end
        for (int b = 0; b < 8; b++) ftx.push_back(flag[b]);
        len = ftx.size();
        rdpos.push_back(7);
        for (int i = 1; i < fb.size(); i++) rdpos.push_back(endpos[i - 1]);
        last_end = endpos[fb.size() - 1];
        ab_at = abort_mode;
        if (abort_mode == -2) ab_at = $urandom_range(0, len - 1);
        total = (ab_at < 0) ? len : ab_at + 9;
        for (int j = 0; j < total; j++) begin
            dv = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            ab = 1'b0;
            erd = 1'b0;
            if (j == 7) d = fb[0];
            for (int i = 0; i < rdpos.size(); i++) begin
                if (rdpos[i] == j) begin
                    erd = (ab_at < 0) || (j < ab_at);
                    if (i > 0) begin
                        dv = 1'b1;
                        d  = fb[i];
                    end
                end
            end
            if (j == last_end) dv = 1'b0;
            if (ab_at >= 0 && j == ab_at) ab = 1'b1;
            if (ab_at >= 0 && j > ab_at) ab = 1'($urandom_range(0, 1));
            if (ab_at < 0 || j <= ab_at) etx = ftx[j];
            else etx = (j != ab_at + 1);
            eabt = (ab_at >= 0) && (j == ab_at + 1);
            step($sformatf("frame f%0d c%0d", fno, j), dv, d, ab,
                 etx, 1'b1, erd, eabt);
        end
        fno++;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 4))
            0: return 8'hFF;
            1: return 8'hF8;
            2: return 8'($urandom) | 8'($urandom);
            3: return 8'h1F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        Rst = 1'b1;
        Tx_DataValid = 1'b0;
        Tx_Data = 8'd0;
        Tx_AbortFrame = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset tx", Tx, 1'b1);
        check("reset busy", Tx_Busy, 1'b0);
        check("reset rdbuff", Tx_RdBuff, 1'b0);
        check("reset aborted", Tx_AbortedTrans, 1'b0);
        Rst = 1'b0;

        idle(20, 0);
        fb = '{8'h00};
        idle(2, 1);
        run_frame(-1);
        fb = '{8'hFF};
        idle(1, 1);
        run_frame(-1);
        fb = '{8'hF8, 8'h03};
        idle(1, 1);
        run_frame(-1);
        fb = '{8'h55, 8'h12};
        idle(3, 1);
        run_frame(11);
        fb = '{8'h0F, 8'h33};
        idle(2, 1);
        run_frame(15);
        idle(2, 0);

        // asynchronous reset in the middle of a data byte
        Tx_AbortFrame = 1'b0;
        Tx_DataValid = 1'b1;
        Tx_Data = 8'hFF;
        repeat (12) @(posedge Clk);
        #3;
        check("midrst busy before", Tx_Busy, 1'b1);
        Rst = 1'b1;
        #1;
        check("midrst tx", Tx, 1'b1);
        check("midrst busy", Tx_Busy, 1'b0);
        check("midrst rdbuff", Tx_RdBuff, 1'b0);
        check("midrst aborted", Tx_AbortedTrans, 1'b0);
        Tx_DataValid = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        idle(6, 0);

        for (int f = 0; f < 60; f++) begin
            fb.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) fb.push_back(rand_byte());
            idle($urandom_range(1, 4), 1);
            run_frame(($urandom_range(0, 3) == 0) ? -2 : -1);
        end
        idle(5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_channel.md
HDLC_TX_CHANNEL -- requirements
Module: hdlc_tx_channel

Interface
REQ-001 SHALL have ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Tx_DataValid  in  1  a byte is available on Tx_Data.
- Tx_Data  in  8  next byte to send; transmitted LSB first.
- Tx_AbortFrame  in  1  request abort of the current frame.
- Tx_RdBuff  out  1  one-cycle pulse; Tx_Data is consumed on this cycle's rising edge.
- Tx_AbortedTrans  out  1  one-cycle pulse when an abort starts.
- Tx_Busy  out  1  high in every state except IDLE.
- Tx  out  1  registered serial line output.

Function
REQ-002 SHALL implement the states IDLE, START_FLAG, DATA, END_FLAG and ABORT.
REQ-003 IDLE SHALL drive Tx=1 continuously (idle pattern) and SHALL NOT pulse Tx_RdBuff.
REQ-004 When Tx_DataValid=1 is sampled in IDLE at edge k, the block SHALL enter START_FLAG and drive Tx=0 in cycle k+1.
REQ-005 The flag SHALL be 8 cycles with Tx = 0,1,1,1,1,1,1,0.
REQ-006 The flag bits SHALL NOT be counted by the ones counter.
REQ-007 The block SHALL pulse Tx_RdBuff during the last flag-bit cycle (k+8) and latch Tx_Data into an 8-bit shift register at the end of that cycle.
REQ-008 Data bit 0 SHALL appear at cycle k+9.
REQ-009 DATA SHALL output one bit per cycle, LSB first.
REQ-010 A 3-bit ones counter SHALL count consecutive 1s driven in DATA and SHALL be cleared by any 0 driven, including inserted zeros.
REQ-011 After five consecutive 1s, the next cycle SHALL drive an inserted 0, the shift register SHALL stall for that cycle, and the counter SHALL clear.
REQ-012 Zero insertion SHALL operate across byte boundaries: the counter is not cleared on a byte load.
REQ-013 The byte-end cycle SHALL be the cycle driving bit 7.
REQ-014 If bit 7 completes a run of five 1s, the byte-end cycle SHALL instead be the following inserted-zero cycle.
REQ-015 If Tx_DataValid=1 in the byte-end cycle, the block SHALL pulse Tx_RdBuff in that cycle and SHALL drive bit 0 of the new byte in the next cycle, with no gap.
REQ-016 If Tx_DataValid=0 in the byte-end cycle, the block SHALL enter END_FLAG and drive the 8-bit flag, then IDLE.
REQ-017 Tx_DataValid SHALL be ignored in every state other than IDLE and the byte-end cycle.
REQ-018 After END_FLAG, IDLE SHALL last at least 1 cycle with Tx=1 before a new START_FLAG.
REQ-019 Tx_AbortFrame=1 sampled in START_FLAG, DATA or END_FLAG SHALL cause the block, in the next cycle, to:
- enter ABORT;
- pulse Tx_AbortedTrans for 1 cycle;
- drive Tx=0;
- clear the shift register and the ones counter.
REQ-020 ABORT SHALL drive 0 followed by seven 1s (8 cycles total), then enter IDLE, with no closing flag.
REQ-021 Tx_AbortFrame SHALL be ignored in IDLE and in ABORT.
REQ-022 If Tx_AbortFrame and the byte-end condition with Tx_DataValid=1 occur in the same cycle, the abort SHALL win and Tx_RdBuff SHALL NOT pulse.
REQ-023 Tx_RdBuff SHALL pulse exactly once per byte transmitted and never twice in consecutive cycles unless consecutive bytes are loaded.

Reset
REQ-024 Rst=1 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE;
- Tx=1;
- Tx_RdBuff=0;
- Tx_AbortedTrans=0;
- Tx_Busy=0;
- shift register = 0;
- ones counter = 0.
REQ-025 Reset mid-frame SHALL abandon the frame without driving an abort pattern; after Rst falls, the block SHALL idle until Tx_DataValid is sampled.

Verification
REQ-026 Single byte 0x00, Tx_DataValid dropped after the first Tx_RdBuff -> Tx = 01111110, 00000000, 01111110, then 1s; exactly 1 Tx_RdBuff pulse; Tx_Busy high for 24 cycles.
REQ-027 Single byte 0xFF -> data field 11111 0 111 (9 cycles), then flag 01111110.
REQ-028 Bytes 0xF8 then 0x03 -> data 00011111 0 11000000; second Tx_RdBuff pulse on the inserted-zero cycle.
REQ-029 Abort asserted during bit 3 of a byte -> next cycle Tx_AbortedTrans=1, Tx = 0 then 1111111, then idle 1s; no further Tx_RdBuff.
REQ-030 Rst=1 asynchronously during DATA -> Tx=1 and Tx_Busy=0 before the next edge; no Tx_RdBuff; a new frame after release starts with a full flag.
REQ-031 Tx_DataValid=0 for 20 cycles -> Tx=1 constant, Tx_Busy=0, no pulses.
